// File: rtl/captura_pkg.sv
// captura_pkg: code constants shared with the decoder, FSM state type and
// the default debounce length for the input-capture stage.
`default_nettype none

package captura_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 16;

    localparam logic [6:0] C1 = 7'h01;
    localparam logic [6:0] C2 = 7'h12;
    localparam logic [6:0] C3 = 7'h24;
    localparam logic [6:0] C4 = 7'h3A;
    localparam logic [6:0] C5 = 7'h15;
    localparam logic [6:0] C6 = 7'h48;

    typedef enum logic [2:0] {
        ST_IDLE             = 3'd0,
        ST_DEBOUNCE_PRESS   = 3'd1,
        ST_EMIT             = 3'd2,
        ST_WAIT_RELEASE     = 3'd3,
        ST_DEBOUNCE_RELEASE = 3'd4
    } estado_t;

    function automatic logic codigo_valido(input logic [6:0] codigo);
        return (codigo == C1) || (codigo == C2) || (codigo == C3) ||
               (codigo == C4) || (codigo == C5) || (codigo == C6);
    endfunction

endpackage

`default_nettype wire

// File: rtl/captura_entrada_filtro_rebote.sv
// filtro_rebote: saturating stability counter; o_stable is high once i_value
// has held the same value for DEBOUNCE_CYCLES consecutive cycles.
`default_nettype none

module filtro_rebote #(
    parameter int WIDTH           = 7,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_clear,
    output logic             o_stable
);

    localparam logic [CNT_W-1:0] c_SAT = CNT_W'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             w_changed;
    logic [CNT_W-1:0] w_cnt;

    // The visible count is zero in the very cycle the value differs from the
    // previous one, so a fresh value starts counting immediately.
    assign w_changed = (i_value != r_prev);
    assign w_cnt     = (w_changed || i_clear) ? '0 : r_cnt;
    assign o_stable  = (w_cnt == c_SAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_prev <= i_value;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (w_cnt == c_SAT) begin
                r_cnt <= c_SAT;
            end else begin
                r_cnt <= w_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/captura_entrada.sv
// captura_entrada: synchronise and debounce switches and confirm button, emit a
// one-cycle Controle strobe with the code. Option macro: CODIGO_VALIDO_EN (adds Erro).
`default_nettype none

module captura_entrada
    import captura_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [6:0] Chaves,
    input  logic       Botao,
    output logic [6:0] Entrada,
    output logic       Controle,
`ifdef CODIGO_VALIDO_EN
    output logic       Erro,
`endif
    output logic       Ocupado
);

    localparam logic [CNT_W-1:0] c_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [6:0]       r_chs_m;
    logic [6:0]       r_chs;
    logic             r_bts_m;
    logic             r_bts;
    estado_t          r_estado;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_entrada;
    logic             r_controle;
    logic             w_estavel;
`ifdef CODIGO_VALIDO_EN
    logic             r_erro;
`endif

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_chs_m <= '0;
            r_chs   <= '0;
            r_bts_m <= 1'b0;
            r_bts   <= 1'b0;
        end else begin
            r_chs_m <= Chaves;
            r_chs   <= r_chs_m;
            r_bts_m <= Botao;
            r_bts   <= r_bts_m;
        end
    end

    filtro_rebote #(
        .WIDTH           (7),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_filtro_chaves (
        .clk      (clk),
        .rst_n    (Reset),
        .i_value  (r_chs),
        .i_clear  (1'b0),
        .o_stable (w_estavel)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_estado   <= ST_IDLE;
            r_cnt      <= '0;
            r_entrada  <= '0;
            r_controle <= 1'b0;
`ifdef CODIGO_VALIDO_EN
            r_erro     <= 1'b0;
`endif
        end else begin
            r_controle <= 1'b0;
`ifdef CODIGO_VALIDO_EN
            r_erro     <= 1'b0;
`endif
            unique case (r_estado)
                ST_IDLE: begin
                    if (r_bts) begin
                        r_estado <= ST_DEBOUNCE_PRESS;
                        r_cnt    <= '0;
                    end
                end
                ST_DEBOUNCE_PRESS: begin
                    if (!r_bts) begin
                        r_estado <= ST_IDLE;
                    end else if (r_cnt == c_FIM) begin
                        // Counter parks at c_FIM until the switches settle.
                        if (w_estavel) begin
                            r_estado <= ST_EMIT;
`ifdef CODIGO_VALIDO_EN
                            if (codigo_valido(r_chs)) begin
                                r_entrada  <= r_chs;
                                r_controle <= 1'b1;
                            end else begin
                                r_erro <= 1'b1;
                            end
`else
                            r_entrada  <= r_chs;
                            r_controle <= 1'b1;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_EMIT: begin
                    r_estado <= ST_WAIT_RELEASE;
                end
                ST_WAIT_RELEASE: begin
                    if (!r_bts) begin
                        r_estado <= ST_DEBOUNCE_RELEASE;
                        r_cnt    <= '0;
                    end
                end
                ST_DEBOUNCE_RELEASE: begin
                    if (r_bts) begin
                        r_estado <= ST_WAIT_RELEASE;
                    end else if (r_cnt == c_FIM) begin
                        r_estado <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_estado <= ST_IDLE;
                end
            endcase
        end
    end

    assign Entrada  = r_entrada;
    assign Controle = r_controle;
    assign Ocupado  = (r_estado != ST_IDLE);
`ifdef CODIGO_VALIDO_EN
    assign Erro     = r_erro;
`endif

endmodule

`default_nettype wire
